// File: rtl/load_use_scoreboard_if.sv
// Decode-to-issue hazard bundle for the load-use scoreboard.
// Master drives decode/completion info; slave returns issue control.
interface load_use_scoreboard_if;
   logic       i_valid;
   logic       i_uses_rs;
   logic [4:0] i_rs_addr;
   logic       i_uses_rt;
   logic [4:0] i_rt_addr;
   logic       i_uses_rw;
   logic [4:0] i_rw_addr;
   logic       i_is_load;
   logic       i_ex_ready;
   logic       done_valid;
   logic [4:0] done_addr;
   logic       kill_valid;
   logic [4:0] kill_addr;
   logic       o_issue;
   logic       o_stall;
   logic [2:0] o_inflight;
   logic       o_error;

   modport master (
      output i_valid, i_uses_rs, i_rs_addr,
      output i_uses_rt, i_rt_addr,
      output i_uses_rw, i_rw_addr,
      output i_is_load, i_ex_ready,
      output done_valid, done_addr,
      output kill_valid, kill_addr,
      input  o_issue, o_stall,
      input  o_inflight, o_error
   );

   modport slave (
      input  i_valid, i_uses_rs, i_rs_addr,
      input  i_uses_rt, i_rt_addr,
      input  i_uses_rw, i_rw_addr,
      input  i_is_load, i_ex_ready,
      input  done_valid, done_addr,
      input  kill_valid, kill_addr,
      output o_issue, o_stall,
      output o_inflight, o_error
   );
endinterface

// File: rtl/load_use_scoreboard.sv
// Decode-stage load-use hazard controller: per-register outstanding
// load counters plus a global in-flight cap; sequences issue only.
module load_use_scoreboard #(
   parameter int MAX_INFLIGHT = 4,
   parameter int CNT_W        = 2
) (
   input logic                  clk,
   input logic                  rst,
   load_use_scoreboard_if.slave bus
);
   localparam int         CNT_MAX = (1 << CNT_W) - 1;
   localparam logic [2:0] MAX_T   = 3'(MAX_INFLIGHT);

   logic [CNT_W-1:0] cnt     [32];
   logic [CNT_W-1:0] cnt_nxt [32];
   logic [2:0]       total;
   logic [2:0]       total_nxt;
   logic             err;
   logic             err_nxt;

   logic        rs_busy;
   logic        rt_busy;
   logic        raw;
   logic        strc;
   logic        hold;
   logic        issue;
   logic        ld_issue;
   logic        dn_any;
   logic        kl_any;
   logic [31:0] inc_vec;
   logic [31:0] dn_vec;
   logic [31:0] kl_vec;
   int          v;
   int          tv;

   assign rs_busy = bus.i_uses_rs && bus.i_rs_addr != 5'd0
                 && cnt[bus.i_rs_addr] != '0;
   assign rt_busy = bus.i_uses_rt && bus.i_rt_addr != 5'd0
                 && cnt[bus.i_rt_addr] != '0;
   assign raw     = rs_busy | rt_busy;

   assign strc = bus.i_is_load && bus.i_uses_rw
              && bus.i_rw_addr != 5'd0
              && (total == MAX_T
                  || int'(cnt[bus.i_rw_addr]) == CNT_MAX);

   assign hold  = raw | strc;
   assign issue = bus.i_valid & bus.i_ex_ready & ~hold & ~rst;

   assign bus.o_issue    = issue;
   assign bus.o_stall    = bus.i_valid & hold & ~rst;
   assign bus.o_inflight = total;
   assign bus.o_error    = err;

   // Register 0 is never tracked, so zero addresses drop out here.
   assign ld_issue = issue & bus.i_is_load & bus.i_uses_rw
                   & (bus.i_rw_addr != 5'd0);
   assign dn_any   = bus.done_valid & (bus.done_addr != 5'd0);
   assign kl_any   = bus.kill_valid & (bus.kill_addr != 5'd0);

   assign inc_vec = ld_issue ? (32'd1 << bus.i_rw_addr) : 32'd0;
   assign dn_vec  = dn_any ? (32'd1 << bus.done_addr) : 32'd0;
   assign kl_vec  = kl_any ? (32'd1 << bus.kill_addr) : 32'd0;

   always_comb begin
      err_nxt    = err;
      v          = 0;
      cnt_nxt[0] = '0;
      for (int r = 1; r < 32; r++) begin
         v = int'(cnt[r]) + int'(inc_vec[r])
           - int'(dn_vec[r]) - int'(kl_vec[r]);
         if (v < 0) begin
            cnt_nxt[r] = '0;
            err_nxt    = 1'b1;
         end else if (v > CNT_MAX) begin
            cnt_nxt[r] = CNT_W'(CNT_MAX);
            err_nxt    = 1'b1;
         end else begin
            cnt_nxt[r] = CNT_W'(v);
         end
      end
   end

   // Total uses the same raw terms; it clamps on its own result.
   always_comb begin
      tv = int'(total) + int'(ld_issue)
         - int'(dn_any) - int'(kl_any);
      if (tv < 0) begin
         total_nxt = 3'd0;
      end else if (tv > 7) begin
         total_nxt = 3'd7;
      end else begin
         total_nxt = 3'(tv);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 32; r++) begin
            cnt[r] <= '0;
         end
         total <= 3'd0;
         err   <= 1'b0;
      end else begin
         for (int r = 0; r < 32; r++) begin
            cnt[r] <= cnt_nxt[r];
         end
         total <= total_nxt;
         err   <= err_nxt | (tv < 0) | (tv > 7);
      end
   end
endmodule

// File: tb/tb_load_use_scoreboard.sv
// Self-checking bench for load_use_scoreboard: directed scenarios
// plus randomized traffic against a queue-of-outstanding-loads model.
module tb_load_use_scoreboard;
   logic clk;
   logic rst;
   int   nchk;
   int   nfail;

   load_use_scoreboard_if bus ();

   load_use_scoreboard #(
      .MAX_INFLIGHT(4),
      .CNT_W       (2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic urs,
                      input logic [4:0] rs, input logic urt,
                      input logic [4:0] rt, input logic urw,
                      input logic [4:0] rw, input logic ld,
                      input logic rdy);
      bus.i_valid    = v;
      bus.i_uses_rs  = urs;
      bus.i_rs_addr  = rs;
      bus.i_uses_rt  = urt;
      bus.i_rt_addr  = rt;
      bus.i_uses_rw  = urw;
      bus.i_rw_addr  = rw;
      bus.i_is_load  = ld;
      bus.i_ex_ready = rdy;
   endtask

   task automatic cmp(input logic dv, input logic [4:0] da,
                      input logic kv, input logic [4:0] ka);
      bus.done_valid = dv;
      bus.done_addr  = da;
      bus.kill_valid = kv;
      bus.kill_addr  = ka;
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cmp(0, 0, 0, 0);
   endtask

   // Present a load and expect it to issue.
   task automatic issue_load(input logic [4:0] rw, input string nm);
      drv(1, 0, 0, 0, 0, 1, rw, 1, 1);
      #1;
      nchk++;
      if (bus.o_issue !== 1'b1) begin
         nfail++;
         $display("FAIL %s: o_issue=%b want 1", nm, bus.o_issue);
      end
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drv(1, 0, 0, 0, 0, 1, 5'd3, 1, 1);
      cmp(0, 0, 0, 0);
      #1;
      nchk++;
      if (bus.o_issue !== 1'b0 || bus.o_stall !== 1'b0) begin
         nfail++;
         $display("FAIL rst_hold: issue=%b stall=%b want 0 0",
                  bus.o_issue, bus.o_stall);
      end
      step();
      step();
      rst = 1'b0;
      idle();
      #1;
      nchk++;
      if (bus.o_inflight !== 3'd0 || bus.o_error !== 1'b0) begin
         nfail++;
         $display("FAIL rst_state: inflight=%0d err=%b want 0 0",
                  bus.o_inflight, bus.o_error);
      end
   endtask

   task automatic test_load_use();
      issue_load(5'd8, "lu_lw");
      drv(1, 1, 5'd8, 0, 0, 1, 5'd10, 0, 1);
      #1;
      nchk++;
      if (bus.o_stall !== 1'b1 || bus.o_issue !== 1'b0
          || bus.o_inflight !== 3'd1) begin
         nfail++;
         $display("FAIL lu_stall: stall=%b issue=%b infl=%0d want 1 0 1",
                  bus.o_stall, bus.o_issue, bus.o_inflight);
      end
      cmp(1, 5'd8, 0, 0);
      #1;
      nchk++;
      if (bus.o_stall !== 1'b1) begin
         nfail++;
         $display("FAIL lu_nobypass: stall=%b want 1", bus.o_stall);
      end
      step();
      cmp(0, 0, 0, 0);
      #1;
      nchk++;
      if (bus.o_issue !== 1'b1 || bus.o_inflight !== 3'd0) begin
         nfail++;
         $display("FAIL lu_release: issue=%b infl=%0d want 1 0",
                  bus.o_issue, bus.o_inflight);
      end
      step();
      idle();
   endtask

   task automatic test_reg_zero();
      issue_load(5'd0, "z_lw");
      drv(1, 1, 5'd0, 1, 5'd0, 0, 0, 0, 1);
      cmp(1, 5'd0, 1, 5'd0);
      #1;
      nchk++;
      if (bus.o_issue !== 1'b1 || bus.o_stall !== 1'b0
          || bus.o_inflight !== 3'd0) begin
         nfail++;
         $display("FAIL z_use: issue=%b stall=%b infl=%0d want 1 0 0",
                  bus.o_issue, bus.o_stall, bus.o_inflight);
      end
      step();
      idle();
      #1;
      nchk++;
      if (bus.o_error !== 1'b0 || bus.o_inflight !== 3'd0) begin
         nfail++;
         $display("FAIL z_done: err=%b infl=%0d want 0 0",
                  bus.o_error, bus.o_inflight);
      end
   endtask

   task automatic test_capacity();
      for (int r = 1; r <= 4; r++) issue_load(5'(r), "cap_lw");
      drv(1, 0, 0, 0, 0, 1, 5'd5, 1, 1);
      #1;
      nchk++;
      if (bus.o_inflight !== 3'd4 || bus.o_stall !== 1'b1
          || bus.o_issue !== 1'b0) begin
         nfail++;
         $display("FAIL cap_full: infl=%0d stall=%b issue=%b want 4 1 0",
                  bus.o_inflight, bus.o_stall, bus.o_issue);
      end
      drv(1, 1, 5'd6, 1, 5'd7, 1, 5'd3, 0, 1);
      #1;
      nchk++;
      if (bus.o_issue !== 1'b1) begin
         nfail++;
         $display("FAIL cap_alu: issue=%b want 1", bus.o_issue);
      end
      step();
      drv(1, 0, 0, 0, 0, 1, 5'd5, 1, 1);
      cmp(1, 5'd2, 0, 0);
      step();
      cmp(0, 0, 0, 0);
      #1;
      nchk++;
      if (bus.o_issue !== 1'b1 || bus.o_inflight !== 3'd3) begin
         nfail++;
         $display("FAIL cap_retry: issue=%b infl=%0d want 1 3",
                  bus.o_issue, bus.o_inflight);
      end
      step();
      idle();
      cmp(1, 5'd1, 1, 5'd3);
      step();
      cmp(1, 5'd4, 1, 5'd5);
      step();
      idle();
      #1;
      nchk++;
      if (bus.o_inflight !== 3'd0 || bus.o_error !== 1'b0) begin
         nfail++;
         $display("FAIL cap_drain: infl=%0d err=%b want 0 0",
                  bus.o_inflight, bus.o_error);
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 3; k++) issue_load(5'd9, "sat_lw");
      drv(1, 0, 0, 0, 0, 1, 5'd9, 1, 1);
      #1;
      nchk++;
      if (bus.o_inflight !== 3'd3 || bus.o_stall !== 1'b1
          || bus.o_issue !== 1'b0) begin
         nfail++;
         $display("FAIL sat_4th: infl=%0d stall=%b issue=%b want 3 1 0",
                  bus.o_inflight, bus.o_stall, bus.o_issue);
      end
      idle();
      cmp(1, 5'd9, 1, 5'd9);
      step();
      cmp(1, 5'd9, 0, 0);
      step();
      idle();
      #1;
      nchk++;
      if (bus.o_inflight !== 3'd0 || bus.o_error !== 1'b0) begin
         nfail++;
         $display("FAIL sat_drain: infl=%0d err=%b want 0 0",
                  bus.o_inflight, bus.o_error);
      end
   endtask

   task automatic test_simultaneous();
      issue_load(5'd6, "sim_lw");
      issue_load(5'd6, "sim_lw");
      drv(1, 0, 0, 0, 0, 1, 5'd6, 1, 1);
      cmp(1, 5'd6, 1, 5'd6);
      #1;
      nchk++;
      if (bus.o_issue !== 1'b1 || bus.o_inflight !== 3'd2) begin
         nfail++;
         $display("FAIL sim_issue: issue=%b infl=%0d want 1 2",
                  bus.o_issue, bus.o_inflight);
      end
      step();
      cmp(0, 0, 0, 0);
      drv(1, 1, 5'd6, 0, 0, 0, 0, 0, 1);
      #1;
      nchk++;
      if (bus.o_inflight !== 3'd1 || bus.o_error !== 1'b0
          || bus.o_stall !== 1'b1) begin
         nfail++;
         $display("FAIL sim_net: infl=%0d err=%b stall=%b want 1 0 1",
                  bus.o_inflight, bus.o_error, bus.o_stall);
      end
      cmp(1, 5'd6, 0, 0);
      step();
      idle();
      #1;
      nchk++;
      if (bus.o_inflight !== 3'd0) begin
         nfail++;
         $display("FAIL sim_drain: infl=%0d want 0", bus.o_inflight);
      end
   endtask

   task automatic test_random();
      logic [4:0] q[$];
      logic [4:0] rest[$];
      int         cm[32];
      logic       v, urs, urt, urw, ld, rdy, dv, kv;
      logic [4:0] rs, rt, rw, da, ka;
      logic       raw, strc, hold, e_iss, e_stl;
      int         di, ki;
      for (int n = 0; n < 600; n++) begin
         foreach (cm[r]) cm[r] = 0;
         foreach (q[k]) cm[q[k]]++;
         v   = ($urandom_range(0, 9) < 8);
         urs = 1'($urandom);
         urt = 1'($urandom);
         urw = ($urandom_range(0, 3) != 0);
         ld  = 1'($urandom);
         rdy = ($urandom_range(0, 3) != 0);
         rs  = 5'($urandom_range(0, 7));
         rt  = 5'($urandom_range(0, 7));
         rw  = 5'($urandom_range(0, 7));
         rest = q;
         dv = 1'b0;
         kv = 1'b0;
         da = 5'($urandom_range(0, 31));
         ka = 5'($urandom_range(0, 31));
         if (rest.size() > 0 && $urandom_range(0, 9) < 4) begin
            di = $urandom_range(0, rest.size() - 1);
            da = rest[di];
            dv = 1'b1;
            rest.delete(di);
         end
         if (rest.size() > 0 && $urandom_range(0, 9) < 2) begin
            ki = $urandom_range(0, rest.size() - 1);
            ka = rest[ki];
            kv = 1'b1;
            rest.delete(ki);
         end
         drv(v, urs, rs, urt, rt, urw, rw, ld, rdy);
         cmp(dv, da, kv, ka);
         raw  = (urs && rs != 0 && cm[rs] != 0)
             || (urt && rt != 0 && cm[rt] != 0);
         strc = ld && urw && rw != 0
             && (q.size() == 4 || cm[rw] == 3);
         hold  = raw || strc;
         e_iss = v && rdy && !hold;
         e_stl = v && hold;
         #1;
         nchk++;
         if (bus.o_issue !== e_iss || bus.o_stall !== e_stl
             || bus.o_inflight !== 3'(q.size())
             || bus.o_error !== 1'b0) begin
            nfail++;
            $display("FAIL rnd[%0d]: iss=%b stl=%b infl=%0d err=%b want %b %b %0d 0",
                     n, bus.o_issue, bus.o_stall, bus.o_inflight,
                     bus.o_error, e_iss, e_stl, q.size());
         end
         step();
         q = rest;
         if (e_iss && ld && urw && rw != 0) q.push_back(rw);
      end
      idle();
      while (q.size() > 0) begin
         cmp(1, q[0], 0, 0);
         void'(q.pop_front());
         step();
      end
      idle();
      #1;
      nchk++;
      if (bus.o_inflight !== 3'd0 || bus.o_error !== 1'b0) begin
         nfail++;
         $display("FAIL rnd_drain: infl=%0d err=%b want 0 0",
                  bus.o_inflight, bus.o_error);
      end
   endtask

   task automatic test_error_reset();
      idle();
      cmp(1, 5'd12, 0, 0);
      step();
      cmp(0, 0, 0, 0);
      #1;
      nchk++;
      if (bus.o_error !== 1'b1) begin
         nfail++;
         $display("FAIL err_set: err=%b want 1", bus.o_error);
      end
      step();
      nchk++;
      if (bus.o_error !== 1'b1) begin
         nfail++;
         $display("FAIL err_sticky: err=%b want 1", bus.o_error);
      end
      issue_load(5'd13, "err_lw");
      issue_load(5'd14, "err_lw");
      drv(1, 1, 5'd13, 0, 0, 1, 5'd15, 0, 1);
      #1;
      nchk++;
      if (bus.o_stall !== 1'b1 || bus.o_inflight !== 3'd2) begin
         nfail++;
         $display("FAIL err_dep: stall=%b infl=%0d want 1 2",
                  bus.o_stall, bus.o_inflight);
      end
      rst = 1'b1;
      #1;
      nchk++;
      if (bus.o_issue !== 1'b0 || bus.o_stall !== 1'b0) begin
         nfail++;
         $display("FAIL err_rsthold: issue=%b stall=%b want 0 0",
                  bus.o_issue, bus.o_stall);
      end
      step();
      rst = 1'b0;
      #1;
      nchk++;
      if (bus.o_inflight !== 3'd0 || bus.o_error !== 1'b0
          || bus.o_issue !== 1'b1) begin
         nfail++;
         $display("FAIL err_rst: infl=%0d err=%b issue=%b want 0 0 1",
                  bus.o_inflight, bus.o_error, bus.o_issue);
      end
      step();
      idle();
   endtask

   initial begin
      nchk  = 0;
      nfail = 0;
      rst   = 1'b1;
      idle();
      test_reset();
      test_load_use();
      test_reg_zero();
      test_capacity();
      test_saturation();
      test_simultaneous();
      test_random();
      test_error_reset();
      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end
endmodule

// File: doc/load_use_scoreboard.md
Name: load_use_scoreboard

Overview:
- Decode-stage hazard controller. Sits between the instruction decoder output and the issue/register-read stage.
- Tracks outstanding loads per architectural destination register and stalls issue of any instruction whose rs/rt depends on an unfinished load.
- Also bounds the total number of loads in flight.
- Sequences issue only; holds no data and does no forwarding.

Parameters:
- MAX_INFLIGHT, 4: maximum loads outstanding across all registers (1..7).
- CNT_W, 2: width of each per-register outstanding-load counter. Saturation value is 2^CNT_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_valid  in  1  decoded instruction present
- i_uses_rs  in  1  instruction reads rs
- i_rs_addr  in  5  rs register number
- i_uses_rt  in  1  instruction reads rt
- i_rt_addr  in  5  rt register number
- i_uses_rw  in  1  instruction writes rw
- i_rw_addr  in  5  rw register number
- i_is_load  in  1  memory read (is_mem_access and action READ)
- i_ex_ready  in  1  downstream can accept an instruction this cycle
- done_valid  in  1  a load wrote back / became forwardable this cycle
- done_addr  in  5  destination of the completed load
- kill_valid  in  1  an issued load was squashed (branch flush) this cycle
- kill_addr  in  5  destination of the squashed load
- o_issue  out  1  instruction accepted this cycle
- o_stall  out  1  instruction held in decode this cycle
- o_inflight  out  3  total outstanding loads
- o_error  out  1  sticky: counter underflow or overflow detected

Behaviour:
- State: cnt[1..31], each CNT_W bits; total, 3 bits; err, 1 bit. Register 0 has no entry. Any addr==0 on any port is ignored, for both hazard checks and updates.
- Reset (rst high at a clk edge): all cnt=0, total=0, err=0. While rst is high, o_issue=0 and o_stall=0. o_inflight=0 and o_error=0 the cycle after reset.
- Hazards are evaluated combinationally from the registered state of the current cycle:
  - raw = (i_uses_rs & rs≠0 & cnt[rs]≠0) | (i_uses_rt & rt≠0 & cnt[rt]≠0)
  - struct = i_is_load & i_uses_rw & rw≠0 & (total==MAX_INFLIGHT | cnt[rw]==max)
  - hold = raw | struct
- o_issue = i_valid & i_ex_ready & ~hold & ~rst.
- o_stall = i_valid & hold & ~rst. When i_ex_ready=0 and there is no hazard, neither o_issue nor o_stall is asserted; the backpressure comes from downstream.
- No same-cycle bypass: a done in cycle N clears the hazard starting at cycle N+1.
- Update at each clk edge, per register r:
  - inc = o_issue & i_is_load & i_uses_rw & rw==r
  - dec = (done_valid & done_addr==r) + (kill_valid & kill_addr==r), range 0..2
  - cnt[r] ← cnt[r] + inc − dec
- total updates the same way, using the same terms summed over all registers. Loads with rw==0 are never counted.
- Simultaneous inc and dec on the same register: the net value is applied, with no intermediate state.
- Underflow: a dec larger than cnt[r]+inc clamps cnt[r] to 0 and sets err; total clamps the same way.
- Overflow cannot occur because of the struct check. If it does occur, saturate and set err.
- err is cleared only by rst.
- Non-load writers (ALU ops, jal, jalr) are never tracked; they rely on EX/MEM forwarding.
- done and kill for the same register in one cycle are legal: dec=2.
- Reset mid-operation discards all outstanding state. The surrounding pipeline must be flushed at the same time.

Test Plan:
- Load-use: issue lw rw=8 (cnt[8]→1). Next cycle, add with rs=8 and i_ex_ready=1 → o_stall=1, o_issue=0. done_valid with addr 8 in cycle N → o_issue=1 in N+1; o_inflight goes 1→0.
- Register zero: lw rw=0, then an instruction with rs=0 → no stall, o_inflight stays 0.
- Capacity: issue 4 loads to rw=1,2,3,4 → o_inflight=4. A 5th load (rw=5) → o_stall=1. A non-load with independent sources still issues. A done on register 2 → the 5th load issues the next cycle.
- Per-register saturation: 3 loads to rw=9 → cnt[9]=3. A 4th load to rw=9 stalls even with total<MAX.
- Simultaneous events: in one cycle, issue a load rw=6 while done addr=6 and kill addr=6 with cnt[6]=2 → cnt[6]=1, o_inflight decrements by 1, o_error stays 0.
- Error and reset: done_valid addr=12 with cnt[12]=0 → o_error=1 and sticky. Assert rst with 2 loads outstanding → the following cycle o_inflight=0, o_error=0, and the dependent instruction issues.
